// File: rtl/sal_sched_pkg.sv
// Shared types for the SAL command scheduler: DFI command encoding, arbitration
// classes and a width helper.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  // Arbitration classes, lower value wins
  typedef logic [1:0] cls_t;
  localparam cls_t CLS_COL = 2'd0;
  localparam cls_t CLS_PRE = 2'd1;
  localparam cls_t CLS_REF = 2'd2;
  localparam cls_t CLS_ACT = 2'd3;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/sal_cmd_sched_if.sv
// Bank-controller request/grant bundle plus the DFI command and data-window
// outputs of the scheduler.
interface sal_cmd_sched_if #(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4
);
  import sal_sched_pkg::*;

  localparam int BA_W   = cnt_w(NUM_BANKS);
  localparam int ADDR_W = (RA_W > CA_W) ? RA_W : CA_W;

  logic [NUM_BANKS-1:0]       bk_act_req_i;
  logic [NUM_BANKS-1:0]       bk_rd_req_i;
  logic [NUM_BANKS-1:0]       bk_wr_req_i;
  logic [NUM_BANKS-1:0]       bk_pre_req_i;
  logic [NUM_BANKS-1:0]       bk_ref_req_i;
  logic [NUM_BANKS*RA_W-1:0]  bk_ra_i;
  logic [NUM_BANKS*CA_W-1:0]  bk_ca_i;
  logic [NUM_BANKS*ID_W-1:0]  bk_id_i;
  logic [NUM_BANKS*LEN_W-1:0] bk_len_i;
  logic [NUM_BANKS-1:0]       bk_gnt_o;
  logic [2:0]                 dfi_cmd_o;
  logic [BA_W-1:0]            dfi_ba_o;
  logic [ADDR_W-1:0]          dfi_addr_o;
  logic                       wr_data_en_o;
  logic [ID_W-1:0]            wr_id_o;
  logic                       rd_data_en_o;
  logic [ID_W-1:0]            rd_id_o;
  logic [LEN_W-1:0]           rd_len_o;

  modport master (
    output bk_act_req_i, bk_rd_req_i, bk_wr_req_i, bk_pre_req_i, bk_ref_req_i,
    output bk_ra_i, bk_ca_i, bk_id_i, bk_len_i,
    input  bk_gnt_o, dfi_cmd_o, dfi_ba_o, dfi_addr_o,
    input  wr_data_en_o, wr_id_o, rd_data_en_o, rd_id_o, rd_len_o
  );

  modport slave (
    input  bk_act_req_i, bk_rd_req_i, bk_wr_req_i, bk_pre_req_i, bk_ref_req_i,
    input  bk_ra_i, bk_ca_i, bk_id_i, bk_len_i,
    output bk_gnt_o, dfi_cmd_o, dfi_ba_o, dfi_addr_o,
    output wr_data_en_o, wr_id_o, rd_data_en_o, rd_id_o, rd_len_o
  );

endinterface

// File: rtl/sal_cmd_sched_chk.sv
// Protocol checks for the scheduler: one request flag per bank per cycle and
// no column command issued while the previous burst window is still open.
module sal_cmd_sched_chk #(
  parameter int NUM_BANKS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [NUM_BANKS-1:0] act_req,
  input logic [NUM_BANKS-1:0] rd_req,
  input logic [NUM_BANKS-1:0] wr_req,
  input logic [NUM_BANKS-1:0] pre_req,
  input logic [NUM_BANKS-1:0] ref_req,
  input logic                 rd_ovl,
  input logic                 wr_ovl
);

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      a_one_req: assert property (@(posedge clk) disable iff (!rst_n)
        $countones({act_req[b], rd_req[b], wr_req[b], pre_req[b], ref_req[b]}) <= 32'd1);
    end
  endgenerate

  a_rd_ccd: assert property (@(posedge clk) disable iff (!rst_n) !rd_ovl);
  a_wr_ccd: assert property (@(posedge clk) disable iff (!rst_n) !wr_ovl);

endmodule

// File: rtl/sal_lat_pipe.sv
// Fixed-latency delay line that opens a BURST_CYC-long enable window, tagged
// with the delayed payload, DEPTH cycles after each push.
module sal_lat_pipe #(
  parameter int DEPTH     = 1,
  parameter int W         = 1,
  parameter int BURST_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         en,
  output logic [W-1:0] data,
  output logic         ovl
);
  localparam int CNT_W = (BURST_CYC > 1) ? $clog2(BURST_CYC) : 1;

  logic             exit_s;
  logic [W-1:0]     exit_data_s;
  logic             en_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     data_r;

  generate
    if (DEPTH == 1) begin : g_direct
      assign exit_s      = push;
      assign exit_data_s = push_data;
    end else begin : g_shift
      logic [DEPTH-2:0] vld_r;
      logic [W-1:0]     dat_r [DEPTH-1];

      // Delay line: the last stage is the cycle before the window opens
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_r <= '0;
          for (int i = 0; i < DEPTH-1; i++) dat_r[i] <= '0;
        end else begin
          vld_r[0] <= push;
          dat_r[0] <= push_data;
          for (int i = 1; i < DEPTH-1; i++) begin
            vld_r[i] <= vld_r[i-1];
            dat_r[i] <= dat_r[i-1];
          end
        end
      end

      assign exit_s      = vld_r[DEPTH-2];
      assign exit_data_s = dat_r[DEPTH-2];
    end
  endgenerate

  // Window counter; a new exit always wins so back-to-back bursts stay gapless
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_r   <= 1'b0;
      cnt_r  <= '0;
      data_r <= '0;
    end else if (exit_s) begin
      en_r   <= 1'b1;
      cnt_r  <= CNT_W'(BURST_CYC - 1);
      data_r <= exit_data_s;
    end else if (en_r && (cnt_r == '0)) begin
      en_r   <= 1'b0;
    end else if (en_r) begin
      cnt_r  <= cnt_r - CNT_W'(1);
    end
  end

  assign en   = en_r;
  assign data = data_r;
  assign ovl  = exit_s && en_r && (cnt_r != '0);

endmodule

// File: rtl/sal_cmd_sched.sv
// Command scheduler: class-priority round-robin arbiter over the bank
// controllers, registered DFI command output and RD/WR data-window pipes.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int RA_W      = 16,
  parameter int CA_W      = 10,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 4,
  parameter int RL        = 11,
  parameter int WL        = 9,
  parameter int BURST_CYC = 4
) (
  input logic            clk,
  input logic            rst_n,
  sal_cmd_sched_if.slave bus
);
  localparam int BA_W   = cnt_w(NUM_BANKS);
  localparam int ADDR_W = (RA_W > CA_W) ? RA_W : CA_W;

  logic [NUM_BANKS-1:0] col_req_s;
  logic [NUM_BANKS-1:0] cls_req_s;
  logic [NUM_BANKS-1:0] gnt_s;
  cls_t                 cls_s;
  logic                 found_s;
  logic [BA_W-1:0]      win_s;
  logic [BA_W-1:0]      rr_ptr_r;
  cmd_t                 cmd_nxt_s;
  logic [ADDR_W-1:0]    addr_nxt_s;
  cmd_t                 dfi_cmd_r;
  logic [BA_W-1:0]      dfi_ba_r;
  logic [ADDR_W-1:0]    dfi_addr_r;
  logic [ID_W-1:0]      id_r;
  logic [LEN_W-1:0]     len_r;
  logic                 rd_en_s, wr_en_s, rd_ovl_s, wr_ovl_s;
  logic [ID_W+LEN_W-1:0] rd_pl_s;
  logic [ID_W-1:0]      wr_pl_s;

  assign col_req_s = bus.bk_rd_req_i | bus.bk_wr_req_i;

  // Highest requesting class; reset masks every request
  always_comb begin
    cls_s     = CLS_ACT;
    cls_req_s = '0;
    if (!rst_n) begin
      cls_req_s = '0;
    end else if (col_req_s != '0) begin
      cls_s     = CLS_COL;
      cls_req_s = col_req_s;
    end else if (bus.bk_pre_req_i != '0) begin
      cls_s     = CLS_PRE;
      cls_req_s = bus.bk_pre_req_i;
    end else if (bus.bk_ref_req_i != '0) begin
      cls_s     = CLS_REF;
      cls_req_s = bus.bk_ref_req_i;
    end else begin
      cls_s     = CLS_ACT;
      cls_req_s = bus.bk_act_req_i;
    end
  end

  // First requester at or after rr_ptr within the winning class
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      int  idx;
      logic hit;
      idx     = (int'(rr_ptr_r) + i) % NUM_BANKS;
      hit     = !found_s && cls_req_s[idx];
      win_s   = hit ? BA_W'(idx) : win_s;
      found_s = found_s | hit;
    end
  end

  assign gnt_s = found_s ? (NUM_BANKS'(1) << win_s) : '0;

  // Command and zero-extended address for the granted bank
  always_comb begin
    cmd_nxt_s  = CMD_NOP;
    addr_nxt_s = '0;
    if (found_s) begin
      case (cls_s)
        CLS_COL: cmd_nxt_s = bus.bk_rd_req_i[win_s] ? CMD_RD : CMD_WR;
        CLS_PRE: cmd_nxt_s = CMD_PRE;
        CLS_REF: cmd_nxt_s = CMD_REF;
        CLS_ACT: cmd_nxt_s = CMD_ACT;
        default: cmd_nxt_s = CMD_NOP;
      endcase
    end else begin
      cmd_nxt_s = CMD_NOP;
    end
    case (cmd_nxt_s)
      CMD_ACT:        addr_nxt_s = ADDR_W'(bus.bk_ra_i[win_s*RA_W +: RA_W]);
      CMD_RD, CMD_WR: addr_nxt_s = ADDR_W'(bus.bk_ca_i[win_s*CA_W +: CA_W]);
      default:        addr_nxt_s = '0;
    endcase
  end

  // DFI output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfi_cmd_r  <= CMD_NOP;
      dfi_ba_r   <= '0;
      dfi_addr_r <= '0;
      id_r       <= '0;
      len_r      <= '0;
      rr_ptr_r   <= '0;
    end else begin
      dfi_cmd_r  <= cmd_nxt_s;
      dfi_ba_r   <= found_s ? win_s : '0;
      dfi_addr_r <= addr_nxt_s;
      id_r       <= bus.bk_id_i[win_s*ID_W +: ID_W];
      len_r      <= bus.bk_len_i[win_s*LEN_W +: LEN_W];
      if (found_s) begin
        rr_ptr_r <= (win_s == BA_W'(NUM_BANKS - 1)) ? '0 : win_s + BA_W'(1);
      end
    end
  end

  sal_lat_pipe #(.DEPTH(RL), .W(ID_W + LEN_W), .BURST_CYC(BURST_CYC)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dfi_cmd_r == CMD_RD),
    .push_data ({id_r, len_r}),
    .en        (rd_en_s),
    .data      (rd_pl_s),
    .ovl       (rd_ovl_s)
  );

  sal_lat_pipe #(.DEPTH(WL), .W(ID_W), .BURST_CYC(BURST_CYC)) u_wr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dfi_cmd_r == CMD_WR),
    .push_data (id_r),
    .en        (wr_en_s),
    .data      (wr_pl_s),
    .ovl       (wr_ovl_s)
  );

  sal_cmd_sched_chk #(.NUM_BANKS(NUM_BANKS)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .act_req (bus.bk_act_req_i),
    .rd_req  (bus.bk_rd_req_i),
    .wr_req  (bus.bk_wr_req_i),
    .pre_req (bus.bk_pre_req_i),
    .ref_req (bus.bk_ref_req_i),
    .rd_ovl  (rd_ovl_s),
    .wr_ovl  (wr_ovl_s)
  );

  assign bus.bk_gnt_o     = gnt_s;
  assign bus.dfi_cmd_o    = dfi_cmd_r;
  assign bus.dfi_ba_o     = dfi_ba_r;
  assign bus.dfi_addr_o   = dfi_addr_r;
  assign bus.rd_data_en_o = rd_en_s;
  assign bus.rd_id_o      = rd_pl_s[ID_W+LEN_W-1:LEN_W];
  assign bus.rd_len_o     = rd_pl_s[LEN_W-1:0];
  assign bus.wr_data_en_o = wr_en_s;
  assign bus.wr_id_o      = wr_pl_s;

endmodule
